// File: rtl/vga_line_writer.sv
// Command-driven Bresenham line / full-screen clear writer for the VGA index frame buffer.
// Optional build macro VGA_LINE_CLIP_EN: off-screen points are skipped and counted on clip_count.
module vga_line_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [9:0]        cmd_x0,
    input  logic [8:0]        cmd_y0,
    input  logic [9:0]        cmd_x1,
    input  logic [8:0]        cmd_y1,
    input  logic [DATA_W-1:0] cmd_color,
    output logic              busy,
    output logic              done,
    output logic              svga_we,
    output logic [ADDR_W-1:0] address_write,
    output logic [DATA_W-1:0] data_write
`ifdef VGA_LINE_CLIP_EN
    ,
    output logic [19:0]       clip_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_DRAW  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_RES * V_RES - 1);

    state_t state_r, state_s;
    logic [9:0]         x0_r, x1_r, x_r;
    logic [8:0]         y0_r, y1_r, y_r;
    logic [DATA_W-1:0]  color_r;
    logic [10:0]        dx_r;
    logic signed [10:0] dy_r;
    logic               sx_neg_r, sy_neg_r;
    logic signed [11:0] err_r;
    logic [ADDR_W-1:0]  clr_cnt_r;

    logic               cmd_ready_r, busy_r, done_r, we_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  data_r;
    logic               cmd_ready_s, busy_s, done_s, we_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [DATA_W-1:0]  data_s;

    logic               at_end_s, step_x_s, step_y_s;
    logic signed [12:0] e2_s, dx_w_s, dy_w_s, err_sum_s;
    logic [10:0]        dx_set_s, dy_set_s;
    logic [8:0]         dy_abs_s;
    logic signed [11:0] err_set_s;
    logic [ADDR_W-1:0]  y_ext_s, pix_addr_s;

`ifdef VGA_LINE_CLIP_EN
    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [9:0]  V_LIM = 10'(V_RES);
    logic        in_range_s, clip_inc_s;
    logic [19:0] clip_cnt_r;
`endif

    // Setup values, Bresenham step decisions and pixel address of the current point
    always_comb begin
        dx_set_s  = (x1_r >= x0_r) ? {1'b0, x1_r - x0_r} : {1'b0, x0_r - x1_r};
        dy_abs_s  = (y1_r >= y0_r) ? (y1_r - y0_r) : (y0_r - y1_r);
        dy_set_s  = 11'd0 - {2'b00, dy_abs_s};
        err_set_s = $signed({1'b0, dx_set_s}) + $signed({dy_set_s[10], dy_set_s});

        at_end_s  = (x_r == x1_r) && (y_r == y1_r);
        e2_s      = {err_r, 1'b0};
        dx_w_s    = {2'b00, dx_r};
        dy_w_s    = {{2{dy_r[10]}}, dy_r};
        step_x_s  = (e2_s >= dy_w_s);
        step_y_s  = (e2_s <= dx_w_s);
        // both increments use the pre-update error and may sum in one cycle
        err_sum_s = {err_r[11], err_r} + (step_x_s ? dy_w_s : 13'sd0) + (step_y_s ? dx_w_s : 13'sd0);

        y_ext_s    = ADDR_W'(y_r);
        pix_addr_s = (y_ext_s << 4'd9) + (y_ext_s << 4'd7) + ADDR_W'(x_r);
    end

`ifdef VGA_LINE_CLIP_EN
    // Visibility of the current traversal point
    always_comb begin
        in_range_s = ({1'b0, x_r} < H_LIM) && ({1'b0, y_r} < V_LIM);
    end
`endif

    // State register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = cmd_valid ? (cmd_op ? ST_CLEAR : ST_SETUP) : ST_IDLE;
            ST_SETUP: state_s = ST_DRAW;
            ST_DRAW:  state_s = at_end_s ? ST_FIN : ST_DRAW;
            ST_CLEAR: state_s = (clr_cnt_r == CLR_LAST) ? ST_FIN : ST_CLEAR;
            ST_FIN:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output decode; address/data hold whenever no write is issued
    always_comb begin
        we_s   = 1'b0;
        addr_s = addr_r;
        data_s = data_r;
`ifdef VGA_LINE_CLIP_EN
        clip_inc_s = 1'b0;
`endif
        case (state_r)
            ST_DRAW: begin
`ifdef VGA_LINE_CLIP_EN
                if (in_range_s) begin
                    we_s   = 1'b1;
                    addr_s = pix_addr_s;
                    data_s = color_r;
                end else begin
                    clip_inc_s = 1'b1;
                end
`else
                we_s   = 1'b1;
                addr_s = pix_addr_s;
                data_s = color_r;
`endif
            end
            ST_CLEAR: begin
                we_s   = 1'b1;
                addr_s = clr_cnt_r;
                data_s = color_r;
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
        cmd_ready_s = (state_s == ST_IDLE);
        busy_s      = (state_s != ST_IDLE);
        done_s      = (state_r == ST_FIN);
    end

    // Registered outputs
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
        end else begin
            cmd_ready_r <= cmd_ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            data_r      <= data_s;
        end
    end

    // Command latch, Bresenham walk and clear sweep counter
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x0_r <= 10'd0; x1_r <= 10'd0; x_r <= 10'd0;
            y0_r <= 9'd0;  y1_r <= 9'd0;  y_r <= 9'd0;
            color_r   <= {DATA_W{1'b0}};
            dx_r      <= 11'd0;
            dy_r      <= 11'sd0;
            sx_neg_r  <= 1'b0;
            sy_neg_r  <= 1'b0;
            err_r     <= 12'sd0;
            clr_cnt_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        x0_r <= cmd_x0; y0_r <= cmd_y0;
                        x1_r <= cmd_x1; y1_r <= cmd_y1;
                        color_r   <= cmd_color;
                        clr_cnt_r <= {ADDR_W{1'b0}};
                    end
                end
                ST_SETUP: begin
                    dx_r     <= dx_set_s;
                    dy_r     <= $signed(dy_set_s);
                    sx_neg_r <= !(x0_r < x1_r);
                    sy_neg_r <= !(y0_r < y1_r);
                    err_r    <= err_set_s;
                    x_r      <= x0_r;
                    y_r      <= y0_r;
                end
                ST_DRAW: begin
                    if (!at_end_s) begin
                        x_r   <= step_x_s ? (x_r + (sx_neg_r ? 10'h3FF : 10'h001)) : x_r;
                        y_r   <= step_y_s ? (y_r + (sy_neg_r ? 9'h1FF : 9'h001)) : y_r;
                        err_r <= err_sum_s[11:0];
                    end
                end
                ST_CLEAR: clr_cnt_r <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                default: begin
                end
            endcase
        end
    end

`ifdef VGA_LINE_CLIP_EN
    // Per-command count of suppressed points
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clip_cnt_r <= 20'd0;
        end else if ((state_r == ST_IDLE) && cmd_valid) begin
            clip_cnt_r <= 20'd0;
        end else if (clip_inc_s) begin
            clip_cnt_r <= clip_cnt_r + 20'd1;
        end else begin
            clip_cnt_r <= clip_cnt_r;
        end
    end

    assign clip_count = clip_cnt_r;
`endif

    assign cmd_ready     = cmd_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign svga_we       = we_r;
    assign address_write = addr_r;
    assign data_write    = data_r;

endmodule
